// File: rtl/clk_div_prog_if.sv
// ---------------------------------------------------------------------------
// clk_div_prog_if
//
// Purpose:
//   Groups the control and status signals of the programmable clock divider.
//   The clock (clk_in) and the reset (rst) stay plain module ports.
//
// Signals:
//   en         run enable, synchronous to clk_in
//   mode       0 = preset F0, 1 = preset F1, 2 = programmable, 3 = forced low
//   load       one-cycle strobe that captures period_in/high_in into the shadow
//   period_in  programmable period in clk_in cycles
//   high_in    programmable high time in clk_in cycles
//   load_ack   one-cycle pulse when a loaded value becomes active
//   clk_out    divided clock, registered
//   tick       one-cycle pulse on the first cycle of each output period
//
// Modports:
//   master  drives the controls and observes the status (system side)
//   slave   the divider itself
// ---------------------------------------------------------------------------
interface clk_div_prog_if #(
  parameter int WIDTH = 24
);

  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] period_in;
  logic [WIDTH-1:0] high_in;
  logic             load_ack;
  logic             clk_out;
  logic             tick;

  modport master (
    output en,
    output mode,
    output load,
    output period_in,
    output high_in,
    input  load_ack,
    input  clk_out,
    input  tick
  );

  modport slave (
    input  en,
    input  mode,
    input  load,
    input  period_in,
    input  high_in,
    output load_ack,
    output clk_out,
    output tick
  );

endinterface

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
//
// Purpose:
//   Programmable clock divider with pulse-width control. The output clk_out
//   is high for H_act cycles and low for P_act - H_act cycles of clk_in. The
//   rate comes from one of two compile-time presets or from a period/high
//   pair loaded at run time through a shadow register. Every rate change
//   takes effect only at a period boundary, so the output never shows a
//   short or a stretched pulse. A one-cycle tick marks the first cycle of
//   every output period.
//
// Ports:
//   clk_in  system clock
//   rst     asynchronous active-low reset
//   bus     clk_div_prog_if.slave: en, mode, load, period_in, high_in in;
//           load_ack, clk_out, tick out
//
// Parameters:
//   CLK_HZ    input clock frequency in Hz
//   F0_HZ     preset 0 output frequency
//   F1_HZ     preset 1 output frequency
//   DUTY_PCT  preset duty cycle in percent (0..100)
//   WIDTH     counter / period / high-time width in bits
//
// Build option:
//   CLK_DIV_SYNC_IN_EN  when defined, en, mode and load each pass through a
//                       two-flop synchroniser before use and load is
//                       edge-detected on the synchronised signal. Every
//                       input-to-effect latency grows by two cycles.
//                       period_in/high_in are not synchronised; they must be
//                       held stable until the load has been captured.
//                       When undefined, the inputs are treated as
//                       synchronous to clk_in and used directly.
// ---------------------------------------------------------------------------
module clk_div_prog #(
  parameter int CLK_HZ   = 50000000,
  parameter int F0_HZ    = 2257,
  parameter int F1_HZ    = 12257,
  parameter int DUTY_PCT = 20,
  parameter int WIDTH    = 24
) (
  input  logic          clk_in,
  input  logic          rst,
  clk_div_prog_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_F0   = 2'd0,
    MODE_F1   = 2'd1,
    MODE_PROG = 2'd2,
    MODE_LOW  = 2'd3
  } mode_t;

  // Preset periods and high times, integer division as in the predecessor.
  // 64-bit arithmetic keeps P*DUTY_PCT from overflowing for large periods.
  localparam longint P0_RAW = longint'(CLK_HZ) / longint'(F0_HZ);
  localparam longint H0_RAW = (P0_RAW * longint'(DUTY_PCT)) / 64'sd100;
  localparam longint P1_RAW = longint'(CLK_HZ) / longint'(F1_HZ);
  localparam longint H1_RAW = (P1_RAW * longint'(DUTY_PCT)) / 64'sd100;

  // The presets obey the same clamping rules as loaded values, so the reset
  // state is already a legal active pair.
  localparam longint P0_CLP = (P0_RAW < 2) ? 64'sd2 : P0_RAW;
  localparam longint H0_CLP = (H0_RAW > P0_CLP) ? P0_CLP : H0_RAW;
  localparam longint P1_CLP = (P1_RAW < 2) ? 64'sd2 : P1_RAW;
  localparam longint H1_CLP = (H1_RAW > P1_CLP) ? P1_CLP : H1_RAW;

  localparam logic [WIDTH-1:0] P0_W  = WIDTH'(P0_CLP);
  localparam logic [WIDTH-1:0] H0_W  = WIDTH'(H0_CLP);
  localparam logic [WIDTH-1:0] P1_W  = WIDTH'(P1_CLP);
  localparam logic [WIDTH-1:0] H1_W  = WIDTH'(H1_CLP);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] P_MIN = WIDTH'(2);

  // Effective control inputs after the optional synchroniser.
  logic  w_en;
  mode_t w_mode;
  logic  w_load;

`ifdef CLK_DIV_SYNC_IN_EN
  logic [1:0] r_enSync;
  logic [1:0] r_modeSync0;
  logic [1:0] r_modeSync1;
  logic [1:0] r_loadSync;
  logic       r_loadPrev;

  // Two-flop synchronisers for the asynchronous controls. The extra flop on
  // load remembers the previous synchronised level so a long load pulse
  // still captures only once.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_enSync    <= 2'b00;
      r_modeSync0 <= 2'b00;
      r_modeSync1 <= 2'b00;
      r_loadSync  <= 2'b00;
      r_loadPrev  <= 1'b0;
    end else begin
      r_enSync    <= {r_enSync[0], bus.en};
      r_modeSync0 <= bus.mode;
      r_modeSync1 <= r_modeSync0;
      r_loadSync  <= {r_loadSync[0], bus.load};
      r_loadPrev  <= r_loadSync[1];
    end
  end

  assign w_en   = r_enSync[1];
  assign w_mode = mode_t'(r_modeSync1);
  assign w_load = r_loadSync[1] & ~r_loadPrev;
`else
  assign w_en   = bus.en;
  assign w_mode = mode_t'(bus.mode);
  assign w_load = bus.load;
`endif

  // Period counter, active pair, shadow pair and output registers.
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_pAct;
  logic [WIDTH-1:0] r_hAct;
  mode_t            r_modeAct;
  logic [WIDTH-1:0] r_pSh;
  logic [WIDTH-1:0] r_hSh;
  logic             r_pending;
  logic             r_clkOut;
  logic             r_tick;
  logic             r_loadAck;

  logic             w_boundary;
  logic [WIDTH-1:0] w_cntInc;
  logic [WIDTH-1:0] w_pSel;
  logic [WIDTH-1:0] w_hSel;
  logic [WIDTH-1:0] w_pNew;
  logic [WIDTH-1:0] w_hNew;

  // The boundary is the last cycle of the current period. It also fires on
  // the first enabled edge after en was low, because the counter is parked
  // at P_act-1 while disabled.
  assign w_boundary = w_en && (r_cnt == (r_pAct - ONE));
  assign w_cntInc   = r_cnt + ONE;

  // Pair that would become active at a boundary: select by the requested
  // mode, then clamp. Forced-low mode keeps the P0 period so tick keeps its
  // preset rate; the output is gated off separately.
  always_comb begin
    w_pSel = P0_W;
    w_hSel = H0_W;
    case (w_mode)
      MODE_F1: begin
        w_pSel = P1_W;
        w_hSel = H1_W;
      end
      MODE_PROG: begin
        w_pSel = r_pSh;
        w_hSel = r_hSh;
      end
      default: begin
        w_pSel = P0_W;
        w_hSel = H0_W;
      end
    endcase
    w_pNew = (w_pSel < P_MIN) ? P_MIN : w_pSel;
    w_hNew = (w_hSel > w_pNew) ? w_pNew : w_hSel;
  end

  // Shadow register. A later load overwrites an earlier one that has not
  // been applied yet. A load that coincides with a boundary wins over the
  // pending clear, so it survives to the following boundary while the
  // boundary itself applies the older shadow contents.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_pSh     <= '0;
      r_hSh     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_load) begin
        r_pSh     <= bus.period_in;
        r_hSh     <= bus.high_in;
        r_pending <= 1'b1;
      end else if (w_boundary && (w_mode == MODE_PROG)) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Divider core. The active pair and mode only change on a boundary, so
  // the running period always completes with the values it started with.
  // clk_out is computed from the counter value it will hold next, which
  // makes the high phase exactly H_act cycles starting at the tick cycle.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_cnt     <= P0_W - ONE;
      r_pAct    <= P0_W;
      r_hAct    <= H0_W;
      r_modeAct <= MODE_F0;
      r_clkOut  <= 1'b0;
      r_tick    <= 1'b0;
      r_loadAck <= 1'b0;
    end else begin
      r_loadAck <= 1'b0;
      if (!w_en) begin
        r_cnt    <= r_pAct - ONE;
        r_clkOut <= 1'b0;
        r_tick   <= 1'b0;
      end else if (w_boundary) begin
        r_cnt     <= '0;
        r_tick    <= 1'b1;
        r_modeAct <= w_mode;
        r_pAct    <= w_pNew;
        r_hAct    <= w_hNew;
        r_clkOut  <= (w_hNew != '0) && (w_mode != MODE_LOW);
        if ((w_mode == MODE_PROG) && r_pending) begin
          r_loadAck <= 1'b1;
        end
      end else begin
        r_cnt    <= w_cntInc;
        r_tick   <= 1'b0;
        r_clkOut <= (w_cntInc < r_hAct) && (r_modeAct != MODE_LOW);
      end
    end
  end

  assign bus.clk_out  = r_clkOut;
  assign bus.tick     = r_tick;
  assign bus.load_ack = r_loadAck;

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
//
// Drives clk_div_prog with directed per-cycle vectors built with the small
// test presets (P0=10/H0=5, P1=4/H1=2). For every clock edge the stimulus
// side queues the tick/clk_out/load_ack values expected after that edge;
// a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_div_prog;

  localparam int WIDTH = 24;

  logic clock = 1'b0;
  logic rst;

  always #5 clock = ~clock;

  clk_div_prog_if #(.WIDTH(WIDTH)) bus ();

  clk_div_prog #(
    .CLK_HZ  (1000),
    .F0_HZ   (100),
    .F1_HZ   (250),
    .DUTY_PCT(50),
    .WIDTH   (WIDTH)
  ) dut (
    .clk_in(clock),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    logic tick;
    logic out;
    logic ack;
    int   step;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   stepNo = 0;

  // One comparison; reports and counts a mismatch.
  task automatic checkOutput(input string name, input logic act, input logic req, input int step);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at step %0d: got %b, required %b", name, step, act, req);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then queue what the
  // outputs must look like after that edge.
  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic ld,
                               input logic [WIDTH-1:0] per, input logic [WIDTH-1:0] hi,
                               input logic eTick, input logic eOut, input logic eAck);
    exp_t x;
    bus.en        = e;
    bus.mode      = m;
    bus.load      = ld;
    bus.period_in = per;
    bus.high_in   = hi;
    @(posedge clock);
    #1;
    x.tick = eTick;
    x.out  = eOut;
    x.ack  = eAck;
    x.step = stepNo;
    stepNo++;
    expQ.push_back(x);
  endtask

  // Run positions fromPos..toPos-1 of a period of length p with high time h.
  // Position 0 is the boundary edge (tick, optional ack). An optional load
  // strobe is issued at position loadPos.
  task automatic runSpan(input logic [1:0] m, input int p, input int h,
                         input int fromPos, input int toPos, input logic ackFirst,
                         input int loadPos, input int lPer, input int lHi);
    for (int pos = fromPos; pos < toPos; pos++) begin
      applyStimulus(1'b1, m, (pos == loadPos), WIDTH'(lPer), WIDTH'(lHi),
                    (pos == 0), (pos < h), (ackFirst && (pos == 0)));
    end
    if (p < toPos) $display("[TB] note: span longer than period %0d", p);
  endtask

  // Monitor: compares the DUT against the queued expectation each falling edge.
  always @(negedge clock) begin
    exp_t x;
    if (expQ.size() > 0) begin
      x = expQ.pop_front();
      checkOutput("tick", bus.tick, x.tick, x.step);
      checkOutput("clk_out", bus.clk_out, x.out, x.step);
      checkOutput("load_ack", bus.load_ack, x.ack, x.step);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst           = 1'b0;
    bus.en        = 1'b0;
    bus.mode      = 2'd0;
    bus.load      = 1'b0;
    bus.period_in = '0;
    bus.high_in   = '0;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_clk_out", bus.clk_out, 1'b0, -1);
    checkOutput("reset_tick", bus.tick, 1'b0, -1);
    checkOutput("reset_load_ack", bus.load_ack, 1'b0, -1);
    @(negedge clock);
    #1;
    rst = 1'b1;

    // Preset 0: 5 high / 5 low, first edge starts a period.
    $display("[TB] preset 0");
    runSpan(2'd0, 10, 5, 0, 10, 1'b0, -1, 0, 0);
    runSpan(2'd0, 10, 5, 0, 10, 1'b0, -1, 0, 0);

    // Switch to preset 1 at cnt=3: running period completes, then 2/2.
    $display("[TB] preset switch");
    runSpan(2'd0, 10, 5, 0, 3, 1'b0, -1, 0, 0);
    runSpan(2'd1, 10, 5, 3, 10, 1'b0, -1, 0, 0);
    runSpan(2'd1, 4, 2, 0, 4, 1'b0, -1, 0, 0);
    runSpan(2'd1, 4, 2, 0, 4, 1'b0, -1, 0, 0);

    // Load 7/3 while still in preset 1, applied at first mode=2 boundary.
    $display("[TB] programmable load");
    runSpan(2'd1, 4, 2, 0, 4, 1'b0, 1, 7, 3);
    runSpan(2'd2, 7, 3, 0, 7, 1'b1, -1, 0, 0);
    runSpan(2'd2, 7, 3, 0, 7, 1'b0, 2, 1, 9);

    // Clamped pair 1/9 -> P=2, H=2: constant high, tick every 2 cycles.
    $display("[TB] clamping");
    runSpan(2'd2, 2, 2, 0, 2, 1'b1, -1, 0, 0);
    runSpan(2'd2, 2, 2, 0, 2, 1'b0, -1, 0, 0);

    // Two loads in one period; the first coincides with a boundary.
    $display("[TB] double load");
    runSpan(2'd2, 2, 2, 0, 1, 1'b0, 0, 6, 1);
    runSpan(2'd2, 2, 2, 1, 2, 1'b0, 1, 8, 2);
    runSpan(2'd2, 8, 2, 0, 8, 1'b1, -1, 0, 0);
    runSpan(2'd2, 8, 2, 0, 3, 1'b0, -1, 0, 0);

    // Disable for 5 cycles mid-period.
    $display("[TB] enable low");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'd2, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    end

    // Re-enable in preset 0, then reset in the middle of the high phase.
    $display("[TB] async reset");
    runSpan(2'd0, 10, 5, 0, 4, 1'b0, -1, 0, 0);
    @(negedge clock);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_clk_out", bus.clk_out, 1'b0, stepNo);
    checkOutput("async_reset_tick", bus.tick, 1'b0, stepNo);
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    rst = 1'b1;
    runSpan(2'd0, 10, 5, 0, 10, 1'b0, -1, 0, 0);

    // Forced low: no output pulses, tick keeps the P0 rate.
    $display("[TB] forced low");
    runSpan(2'd3, 10, 0, 0, 10, 1'b0, -1, 0, 0);
    runSpan(2'd3, 10, 0, 0, 10, 1'b0, -1, 0, 0);

    // Let the monitor drain the queue.
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d entries left, required 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
